// File: rtl/rep3_serial_tx_if.sv
// rep3_serial_tx_if: parallel-in / serial-out bundle for rep3_serial_tx.
// The parallel data source drives master; the transmitter uses slave.
interface rep3_serial_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              tx_valid;
    logic              tx_bit;
    logic              done;

    modport master (
        output start, din,
        input  busy, tx_valid, tx_bit, done
    );

    modport slave (
        input  start, din,
        output busy, tx_valid, tx_bit, done
    );
endinterface

// File: rtl/rep3_serial_tx.sv
// rep3_serial_tx: triple-repetition serial transmitter, MSB first.
// Define REP3_PARITY_EN to append a thrice-repeated odd-parity bit.
module rep3_serial_tx #(
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    rep3_serial_tx_if.slave bus
);
`ifdef REP3_PARITY_EN
    localparam int FW = DATA_W + 1;
`else
    localparam int FW = DATA_W;
`endif
    localparam int CW = $clog2(FW + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [1:0]    rep_q, rep_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          txb_q, txb_d;
    logic          done_q, done_d;
    logic [FW-1:0] frame;

`ifdef REP3_PARITY_EN
    // xnor-reduce makes the ones count of data plus parity odd
    assign frame = {bus.din, ~^bus.din};
`else
    assign frame = bus.din;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SEND;
                    shreg_d = frame;
                    bit_d   = '0;
                    rep_d   = '0;
                end
            end
            SEND: begin
                if (rep_q == 2'd2) begin
                    rep_d = '0;
                    if (bit_q == CW'(FW - 1)) begin
                        state_d = IDLE;
                        shreg_d = '0;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        shreg_d = shreg_q << 1;
                        bit_d   = bit_q + CW'(1);
                    end
                end else begin
                    rep_d = rep_q + 2'd1;
                end
            end
        endcase
        // outputs are registered copies of the next state's view
        busy_d  = (state_d == SEND);
        valid_d = busy_d;
        txb_d   = busy_d & shreg_d[FW-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            txb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            txb_q   <= txb_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.tx_valid = valid_q;
    assign bus.tx_bit   = txb_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_rep3_serial_tx.sv
// tb_rep3_serial_tx: randomized self-checking bench for rep3_serial_tx.
// Reference stream is built directly from the frame rules.
module tb_rep3_serial_tx;
    localparam int DATA_W = 8;
`ifdef REP3_PARITY_EN
    localparam int NB = DATA_W + 1;
`else
    localparam int NB = DATA_W;
`endif
    localparam int FL = 3 * NB;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   exp_bits [FL];

    rep3_serial_tx_if #(.DATA_W(DATA_W)) bus ();

    rep3_serial_tx #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // expected tx_bit for cycles 1..FL, index k-1
    function automatic void build_exp(input logic [DATA_W-1:0] d);
        int b;
        for (int k = 0; k < FL; k++) begin
            b = k / 3;
            if (b < DATA_W) exp_bits[k] = d[DATA_W-1-b];
            else exp_bits[k] = ($countones(d) % 2 == 0);
        end
    endfunction

    function automatic logic [3:0] obs();
        return {bus.busy, bus.tx_valid, bus.tx_bit, bus.done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.din = DATA_W'($urandom);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs() !== 4'b0000) begin
                errors++;
                $display("FAIL reset cyc %0d got %b want 0000", i, obs());
            end
        end
        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs() !== 4'b0000) begin
                errors++;
                $display("FAIL idle cyc %0d got %b want 0000", i, obs());
            end
        end
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] d;
        logic [3:0] e;
        for (int n = 0; n < 6; n++) begin
            d = (n == 0) ? 8'hA5 : DATA_W'($urandom);
            build_exp(d);
            bus.din = d;
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            for (int k = 1; k <= FL; k++) begin
                bus.din = DATA_W'($urandom);
                e = {2'b11, exp_bits[k-1], 1'b0};
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL single d=%h cyc %0d got %b want %b", d, k, obs(), e);
                end
                step();
            end
            checks++;
            if (obs() !== 4'b0001) begin
                errors++;
                $display("FAIL single_done d=%h got %b want 0001", d, obs());
            end
            step();
            checks++;
            if (obs() !== 4'b0000) begin
                errors++;
                $display("FAIL single_after d=%h got %b want 0000", d, obs());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d1, d2;
        logic [3:0] e;
        for (int n = 0; n < 3; n++) begin
            d1 = (n == 0) ? 8'hFF : DATA_W'($urandom);
            d2 = (n == 0) ? 8'h00 : DATA_W'($urandom);
            bus.din = d1;
            bus.start = 1'b1;
            step();
            bus.din = d2;
            build_exp(d1);
            for (int k = 1; k <= FL; k++) begin
                e = {2'b11, exp_bits[k-1], 1'b0};
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL b2b_a cyc %0d got %b want %b", k, obs(), e);
                end
                step();
            end
            checks++;
            if (obs() !== 4'b0001) begin
                errors++;
                $display("FAIL b2b_done1 got %b want 0001", obs());
            end
            step();
            bus.start = 1'b0;
            bus.din = DATA_W'($urandom);
            build_exp(d2);
            for (int k = 1; k <= FL; k++) begin
                e = {2'b11, exp_bits[k-1], 1'b0};
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL b2b_b cyc %0d got %b want %b", k, obs(), e);
                end
                step();
            end
            checks++;
            if (obs() !== 4'b0001) begin
                errors++;
                $display("FAIL b2b_done2 got %b want 0001", obs());
            end
            step();
            checks++;
            if (obs() !== 4'b0000) begin
                errors++;
                $display("FAIL b2b_after got %b want 0000", obs());
            end
        end
    endtask

    task automatic test_busy();
        logic [DATA_W-1:0] d;
        logic [3:0] e;
        for (int n = 0; n < 4; n++) begin
            d = (n == 0) ? 8'h3C : DATA_W'($urandom);
            build_exp(d);
            bus.din = d;
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            for (int k = 1; k <= FL; k++) begin
                if (n == 0) begin
                    bus.start = (k == 10);
                    bus.din = (k == 10) ? 8'hFF : d;
                end else begin
                    bus.start = 1'($urandom_range(0, 1));
                    bus.din = DATA_W'($urandom);
                end
                e = {2'b11, exp_bits[k-1], 1'b0};
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL busy d=%h cyc %0d got %b want %b", d, k, obs(), e);
                end
                step();
            end
            bus.start = 1'b0;
            checks++;
            if (obs() !== 4'b0001) begin
                errors++;
                $display("FAIL busy_done d=%h got %b want 0001", d, obs());
            end
            step();
            checks++;
            if (obs() !== 4'b0000) begin
                errors++;
                $display("FAIL busy_after d=%h got %b want 0000", d, obs());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d;
        logic [3:0] e;
        int cut;
        for (int n = 0; n < 4; n++) begin
            d = (n == 0) ? 8'hA5 : DATA_W'($urandom);
            cut = (n == 0) ? 12 : $urandom_range(1, FL);
            build_exp(d);
            bus.din = d;
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            for (int k = 1; k < cut; k++) step();
            rst = 1'b1;
            bus.start = 1'b1;
            step();
            rst = 1'b0;
            bus.start = 1'b0;
            checks++;
            if (obs() !== 4'b0000) begin
                errors++;
                $display("FAIL rst_mid cut %0d got %b want 0000", cut, obs());
            end
            for (int k = 0; k < FL + 2; k++) begin
                step();
                checks++;
                if (obs() !== 4'b0000) begin
                    errors++;
                    $display("FAIL rst_quiet cyc %0d got %b want 0000", k, obs());
                end
            end
            d = DATA_W'($urandom);
            build_exp(d);
            bus.din = d;
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            for (int k = 1; k <= FL; k++) begin
                e = {2'b11, exp_bits[k-1], 1'b0};
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL rst_new cyc %0d got %b want %b", k, obs(), e);
                end
                step();
            end
            checks++;
            if (obs() !== 4'b0001) begin
                errors++;
                $display("FAIL rst_new_done got %b want 0001", obs());
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.din = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rep3_serial_tx.md
Name: rep3_serial_tx

Overview:
Triple-repetition serial transmitter, the sending end of the team's majority-vote (Y = AB + BC + CA) receiver path. It accepts a parallel word and shifts it out MSB first, one bit per clock. Each data bit is driven on three consecutive cycles, so the downstream 2-of-3 voter can correct any single corrupted repetition. It sits between a parallel data source and a single-wire serial link.

Parameters:
DATA_W, 8, width of the parallel data word in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to transmit din; sampled only when the block can accept.
din  input  DATA_W  parallel data; captured only on the accepting edge.
busy  output  1  high while a frame is being transmitted.
tx_valid  output  1  high on every cycle in which tx_bit carries a frame bit.
tx_bit  output  1  serial output bit; forced to 0 when tx_valid is 0.
done  output  1  one-cycle pulse after the last repetition of a frame.

Behaviour:
- The clock is clk. Reset is rst: synchronous and active-high.
- Reset values:
  - busy=0, tx_valid=0, tx_bit=0, done=0.
  - State = IDLE; shift register, bit counter and repetition counter = 0.
- States:
  - IDLE: waiting for a frame request.
  - SEND: transmitting a frame.
- IDLE -> SEND:
  - Condition: start=1 at a rising edge.
  - On that edge the block captures din into the shift register, sets rep_cnt=0 and bit_cnt=0, and sets busy=1.
- Frame timing:
  - Call the accepting edge cycle 0.
  - In cycles 1..3*DATA_W: tx_valid=1 and busy=1.
  - tx_bit = din[DATA_W-1-(k-1)/3] in cycle k, using integer division.
  - In other words, each bit appears on 3 consecutive cycles, MSB first.
- Counters:
  - rep_cnt counts 0,1,2 for each bit.
  - When rep_cnt wraps from 2 back to 0, the shift register shifts left by one and bit_cnt increments.
- SEND -> IDLE:
  - Taken after the third repetition of the LSB.
  - In cycle 3*DATA_W+1: done=1, busy=0, tx_valid=0, tx_bit=0.
  - done is high for exactly one cycle.
- Latency: first bit appears 1 cycle after the accepting edge; frame length is 3*DATA_W cycles.
- Back-to-back frames:
  - start is also accepted on the edge that ends cycle 3*DATA_W+1 (the done cycle).
  - The next frame's first bit then appears in the following cycle, so the gap between frames is exactly one idle cycle.
- start while busy=1: ignored; din is not re-sampled and the frame in progress is unaffected.
- din changing mid-frame: has no effect on the frame in progress.
- Reset mid-frame:
  - The frame is aborted on the same edge and all outputs return to their reset values.
  - No done pulse is produced for the aborted frame.
- rst and start high on the same edge: rst wins; the block stays in IDLE.
- Registered outputs: tx_bit, tx_valid, busy and done are registered, with no combinational path from inputs.

Optional Feature:
Macro: REP3_PARITY_EN.
- Defined:
  - An odd-parity bit is appended after the LSB. The parity bit makes the total count of ones in data plus parity odd.
  - The parity bit is computed from the captured din.
  - It is repeated 3 times like the data bits.
  - The frame becomes 3*(DATA_W+1) cycles, and done is asserted in cycle 3*(DATA_W+1)+1.
- Not defined: no parity bit; frame timing is exactly as in Behaviour.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release, keep start=0 for 10 cycles -> busy=0, tx_valid=0, tx_bit=0, done=0 throughout.
- Single frame: DATA_W=8, din=8'hA5, pulse start for 1 cycle -> cycles 1..24 tx_bit = 111 000 111 000 000 111 000 111 with tx_valid=1 and busy=1; cycle 25 done=1 and busy=0.
- Back-to-back frames: din=8'hFF then 8'h00, with start held high through the first frame's done cycle -> second frame's first bit in cycle 26; that frame's 24 bits are all 0; second done in cycle 50.
- start/din during busy: after starting with 8'h3C, pulse start with din=8'hFF at cycle 10 -> the stream is still 000 000 111 111 111 111 000 000 and only one done pulse occurs.
- Reset mid-frame: assert rst at cycle 12 of an 8'hA5 frame -> all outputs 0 on the next cycle; no done pulse; a new start then produces a clean 24-cycle frame.
- Parity variant (REP3_PARITY_EN defined), din=8'h01 -> 27 valid cycles; last three bits are 000 (data already has an odd number of ones); done in cycle 28. With din=8'h03 the last three bits are 111.
